// File: rtl/mult_pkg.sv
// Constants shared by the 8x8 multiplier and the product accumulator so their widths agree,
// plus the accumulator's state encoding.
package mult_pkg;

  localparam int MULT_OP_W   = 8;
  localparam int MULT_PROD_W = 2 * MULT_OP_W;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/product_accumulator.sv
// Sums LEN unsigned products into one ACC_W-bit result, with a sticky per-result wrap flag.
// The result is held until the consumer takes it.
module product_accumulator
  import mult_pkg::*;
#(
  parameter int PROD_W = MULT_PROD_W,
  parameter int ACC_W  = 24,
  parameter int LEN    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = $clog2(LEN + 1);

  // Handshake: a product moves on any rising edge where in_valid & in_ready;
  // a result moves on any rising edge where out_valid & out_ready. clear overrides both.
  acc_state_t       state;
  acc_state_t       state_next;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W:0]   sum;
  logic             beat;
  logic             last;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign beat      = in_valid & in_ready;
  assign last      = (cnt == CNT_W'(LEN - 1));

  // One extra bit on the adder captures the wrap carry.
  assign sum = {1'b0, acc} + (ACC_W + 1)'(in_prod);

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (beat && last) state_next = HOLD;
        HOLD:    if (out_ready)    state_next = ACCUM;
        default: state_next = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // out_sum deliberately survives clear; only reset zeroes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (beat) begin
      if (last) begin
        out_sum <= sum[ACC_W-1:0];
        out_ovf <= ovf | sum[ACC_W];
        acc     <= '0;
        cnt     <= '0;
        ovf     <= 1'b0;
      end else begin
        acc <= sum[ACC_W-1:0];
        cnt <= cnt + 1'b1;
        ovf <= ovf | sum[ACC_W];
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: default instance (24-bit, LEN=8) plus a 16-bit LEN=2 instance
// for wrap-around, checked against an arithmetic reference model through result queues.
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic        a_clear = 1'b0, a_valid = 1'b0, a_ready, a_out_valid, a_out_ready = 1'b1, a_ovf;
  logic [15:0] a_prod = '0;
  logic [23:0] a_sum;
  // Instance B: ACC_W=16, LEN=2
  logic        b_clear = 1'b0, b_valid = 1'b0, b_ready, b_out_valid, b_out_ready = 1'b1, b_ovf;
  logic [15:0] b_prod = '0;
  logic [15:0] b_sum;

  product_accumulator u_dut_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear),
    .in_valid(a_valid), .in_ready(a_ready), .in_prod(a_prod),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_sum), .out_ovf(a_ovf)
  );

  product_accumulator #(.ACC_W(16), .LEN(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear),
    .in_valid(b_valid), .in_ready(b_ready), .in_prod(b_prod),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_sum), .out_ovf(b_ovf)
  );

  // Scoreboard: bit 32 = expected overflow, bits 31:0 = expected sum
  logic [32:0] exp_a_q[$];
  logic [32:0] exp_b_q[$];
  logic [15:0] vec_a[$];
  logic [15:0] vec_b[$];
  int n_checks = 0;
  int n_fails  = 0;
  logic rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer total; wrap flagged when the total ever passes 2^acc_w-1.
  function automatic logic [32:0] ref_result(input longint total, input int acc_w);
    longint modulus;
    modulus = longint'(1) << acc_w;
    ref_result = {(total >= modulus), 32'(total % modulus)};
  endfunction

  task automatic model_accept_a(input logic [15:0] v);
    longint total;
    vec_a.push_back(v);
    if (vec_a.size() == 8) begin
      total = 0;
      foreach (vec_a[i]) total += longint'(vec_a[i]);
      exp_a_q.push_back(ref_result(total, 24));
      vec_a.delete();
    end
  endtask

  task automatic model_accept_b(input logic [15:0] v);
    longint total;
    vec_b.push_back(v);
    if (vec_b.size() == 2) begin
      total = 0;
      foreach (vec_b[i]) total += longint'(vec_b[i]);
      exp_b_q.push_back(ref_result(total, 16));
      vec_b.delete();
    end
  endtask

  // Drivers: inputs change 1 time unit after the rising edge; acceptance judged at the falling edge.
  task automatic send_a(input logic [15:0] v);
    bit accepted = 0;
    int tmo = 0;
    a_valid = 1'b1;
    a_prod  = v;
    while (!accepted && tmo < 60) begin
      @(negedge clk);
      accepted = a_ready && !a_clear;
      @(posedge clk);
      #1;
      tmo++;
    end
    a_valid = 1'b0;
    if (accepted) model_accept_a(v);
    else check("send_a_timeout", 32'd1, 32'd0);
  endtask

  task automatic send_b(input logic [15:0] v);
    bit accepted = 0;
    int tmo = 0;
    b_valid = 1'b1;
    b_prod  = v;
    while (!accepted && tmo < 60) begin
      @(negedge clk);
      accepted = b_ready;
      @(posedge clk);
      #1;
      tmo++;
    end
    b_valid = 1'b0;
    if (accepted) model_accept_b(v);
    else check("send_b_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain;
    int tmo = 0;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && tmo < 200) begin
      idle(1);
      tmo++;
    end
    check("drain_timeout", 32'(exp_a_q.size() + exp_b_q.size()), 32'd0);
  endtask

  task automatic wait_valid_a;
    int tmo = 0;
    while (!a_out_valid && tmo < 50) begin
      idle(1);
      tmo++;
    end
    check("wait_valid_a", 32'(a_out_valid), 32'd1);
  endtask

  // Monitors: a result is taken at the next rising edge when valid & ready are both high now.
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready && !a_clear) begin
      if (exp_a_q.size() == 0) begin
        check("a_unexpected_result", 32'd1, 32'd0);
      end else begin
        check("a_sum", 32'(a_sum), exp_a_q[0][31:0]);
        check("a_ovf", 32'(a_ovf), 32'(exp_a_q[0][32]));
        void'(exp_a_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready && !b_clear) begin
      if (exp_b_q.size() == 0) begin
        check("b_unexpected_result", 32'd1, 32'd0);
      end else begin
        check("b_sum", 32'(b_sum), exp_b_q[0][31:0]);
        check("b_ovf", 32'(b_ovf), 32'(exp_b_q[0][32]));
        void'(exp_b_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      a_out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [32:0] held;
    // Reset state
    #2;
    check("rst_a_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd1);
    check("rst_a_sum", 32'(a_sum), 32'd0);
    check("rst_a_ovf", 32'(a_ovf), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Reset mid-vector after a completed result left out_sum non-zero
    for (int i = 0; i < 8; i++) send_a(16'($urandom_range(1, 65535)));
    wait_drain();
    for (int i = 0; i < 3; i++) send_a(16'($urandom_range(1, 100)));
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(a_out_valid), 32'd0);
    check("async_rst_ready", 32'(a_ready), 32'd1);
    check("async_rst_sum", 32'(a_sum), 32'd0);
    vec_a.delete();
    exp_a_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 8; i++) send_a(16'(i + 10));
    wait_drain();

    // Full scale, back-to-back, with latency check
    for (int i = 0; i < 7; i++) send_a(16'hFE01);
    check("lat_before_last", 32'(a_out_valid), 32'd0);
    send_a(16'hFE01);
    check("lat_after_last", 32'(a_out_valid), 32'd1);
    check("full_scale_sum", 32'(a_sum), 32'h07F008);
    check("full_scale_ovf", 32'(a_ovf), 32'd0);
    wait_drain();

    // Backpressure: result held 5 cycles, extra input ignored
    a_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_a(16'($urandom_range(0, 65535)));
    a_valid = 1'b1;
    a_prod  = 16'h1234;
    repeat (5) begin
      @(negedge clk);
      check("bp_ready_low", 32'(a_ready), 32'd0);
      check("bp_valid_high", 32'(a_out_valid), 32'd1);
      if (exp_a_q.size() != 0) check("bp_sum_stable", 32'(a_sum), exp_a_q[0][31:0]);
      else check("bp_no_expected", 32'd1, 32'd0);
      @(posedge clk);
      #1;
    end
    a_valid = 1'b0;
    a_out_ready = 1'b1;
    idle(1);
    check("bp_ready_after_take", 32'(a_ready), 32'd1);
    for (int i = 0; i < 8; i++) send_a(16'(i * 3));
    wait_drain();

    // Wrap-around on the narrow instance
    send_b(16'hFE01);
    send_b(16'hFE01);
    wait_drain();
    send_b(16'd1);
    send_b(16'd2);
    wait_drain();

    // Clear drops a same-cycle beat and the partial sum
    for (int i = 0; i < 3; i++) send_a(16'd1);
    a_valid = 1'b1;
    a_prod  = 16'd1;
    a_clear = 1'b1;
    idle(1);
    a_clear = 1'b0;
    a_valid = 1'b0;
    vec_a.delete();
    for (int i = 0; i < 8; i++) send_a(16'd2);
    wait_drain();

    // Clear while holding a result
    a_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_a(16'($urandom_range(0, 65535)));
    wait_valid_a();
    held = (exp_a_q.size() != 0) ? exp_a_q[0] : 33'd0;
    a_clear = 1'b1;
    idle(1);
    a_clear = 1'b0;
    exp_a_q.delete();
    check("clr_hold_valid", 32'(a_out_valid), 32'd0);
    check("clr_hold_ready", 32'(a_ready), 32'd1);
    check("clr_hold_sum_kept", 32'(a_sum), held[31:0]);
    a_out_ready = 1'b1;

    // Bubbles: values 1..8 with random idle gaps
    for (int i = 1; i <= 8; i++) begin
      idle($urandom_range(0, 3));
      send_a(16'(i));
    end
    wait_drain();

    // Random vectors with random gaps and random consumer stalls
    rand_ready = 1'b1;
    for (int v = 0; v < 15; v++) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        send_a(16'($urandom_range(0, 65535)));
      end
      send_b(16'($urandom_range(0, 65535)));
      send_b(16'($urandom_range(0, 65535)));
    end
    rand_ready = 1'b0;
    #2 a_out_ready = 1'b1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
